// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU port and the
// boot-loader port. Each access runs IDLE -> ISSUE -> WAIT -> RESP and ends
// with a one-cycle ready pulse to the port that owns it. Conflicts are
// resolved round-robin on the last owner.
// Optional build macro MEM_ARB_LD_LOCK_EN adds the ld_lock input, which lets
// the loader keep winning conflicts for gap-free boot bursts.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1    // RAM read latency, 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ready,
`ifdef MEM_ARB_LD_LOCK_EN
  input  logic              ld_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;
  // MEM_LAT-1 is at most 3, so two bits hold every legal count.
  localparam int   CNT_W   = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
  logic                lock_win;
  logic                grant_ld;

  // Loader keeps the RAM on a conflict while locked and it was the last owner.
`ifdef MEM_ARB_LD_LOCK_EN
  assign lock_win = ld_lock & (last_q == OWN_LD);
`else
  assign lock_win = 1'b0;
`endif

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_LD;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Arbitration, access sequencing and output decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    grant_ld    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    cpu_ready   = 1'b0;
    ld_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          grant_ld = ld_req && (!cpu_req || (last_q == OWN_CPU) || lock_win);
          owner_d  = grant_ld;
          last_d   = grant_ld;
          addr_d   = grant_ld ? ld_addr  : cpu_addr;
          we_d     = grant_ld ? ld_we    : cpu_we;
          wdata_d  = grant_ld ? ld_wdata : cpu_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_LD) ld_rdata_d  = mem_rdata;
            else                   cpu_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        cpu_ready = (owner_q == OWN_CPU);
        ld_ready  = (owner_q == OWN_LD);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each in front of a small behavioural RAM whose read data appears
// exactly MEM_LAT cycles after mem_en.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // MEM_LAT=1 instance signals
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wdata, m_rdata;
  logic        c_ready, l_ready, m_en, m_we;
  // MEM_LAT=3 instance signals
  logic        c3_req;
  logic [31:0] c3_addr;
  logic [31:0] c3_rdata, l3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic        c3_ready, l3_ready, m3_en, m3_we;
  logic        z1  = 1'b0;
  logic [31:0] z32 = 32'h0;
`ifdef MEM_ARB_LD_LOCK_EN
  logic        lk;
`endif

  // RAM preload ports
  logic        pre_we1, pre_we3;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_rdata(c_rdata), .cpu_ready(c_ready),
    .ld_req(l_req), .ld_we(l_we), .ld_addr(l_addr), .ld_wdata(l_wdata),
    .ld_rdata(l_rdata), .ld_ready(l_ready),
`ifdef MEM_ARB_LD_LOCK_EN
    .ld_lock(lk),
`endif
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c3_req), .cpu_we(z1), .cpu_addr(c3_addr), .cpu_wdata(z32),
    .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
    .ld_req(z1), .ld_we(z1), .ld_addr(z32), .ld_wdata(z32),
    .ld_rdata(l3_rdata), .ld_ready(l3_ready),
`ifdef MEM_ARB_LD_LOCK_EN
    .ld_lock(z1),
`endif
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata)
  );

  // RAM behind dut1: one-cycle read latency
  logic [31:0] ram1 [0:255];
  logic [31:0] rd1 = 32'h0;
  always @(posedge clk) begin
    if (pre_we1) ram1[pre_a] <= pre_d;
    else if (m_en && m_we) ram1[m_addr[7:0]] <= m_wdata;
    rd1 <= m_en ? ram1[m_addr[7:0]] : 32'h0;
  end
  assign m_rdata = rd1;

  // RAM behind dut3: three-cycle read latency pipeline
  logic [31:0] ram3 [0:255];
  logic [31:0] p3_0 = 32'h0, p3_1 = 32'h0, p3_2 = 32'h0;
  always @(posedge clk) begin
    if (pre_we3) ram3[pre_a] <= pre_d;
    else if (m3_en && m3_we) ram3[m3_addr[7:0]] <= m3_wdata;
    p3_0 <= m3_en ? ram3[m3_addr[7:0]] : 32'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign m3_rdata = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CPU read on dut1 started in the current (IDLE) cycle; ends in cycle 4.
  task automatic cpu_read1(input logic [31:0] a, input logic [31:0] exp,
                           input logic [31:0] exp_ld);
    c_req = 1'b1; c_we = 1'b0; c_addr = a;
    tick();
    check("rd_c1_en",   {31'b0, m_en}, 32'h1);
    check("rd_c1_we",   {31'b0, m_we}, 32'h0);
    check("rd_c1_addr", m_addr, a);
    tick();
    check("rd_c2_en",   {31'b0, m_en}, 32'h0);
    check("rd_c2_rdy",  {31'b0, c_ready}, 32'h0);
    tick();
    check("rd_c3_rdy",  {31'b0, c_ready}, 32'h1);
    check("rd_c3_ld",   {31'b0, l_ready}, 32'h0);
    check("rd_c3_data", c_rdata, exp);
    check("rd_ldata",   l_rdata, exp_ld);
    c_req = 1'b0;
    tick();
    check("rd_c4_rdy",  {31'b0, c_ready}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    c3_req = 0; c3_addr = 0;
`ifdef MEM_ARB_LD_LOCK_EN
    lk = 0;
`endif
    pre_we1 = 0; pre_we3 = 0; pre_a = 0; pre_d = 0;
    tick(); tick();
    // reset state
    check("rst_en",    {31'b0, m_en}, 32'h0);
    check("rst_we",    {31'b0, m_we}, 32'h0);
    check("rst_addr",  m_addr, 32'h0);
    check("rst_wdata", m_wdata, 32'h0);
    check("rst_crdy",  {31'b0, c_ready}, 32'h0);
    check("rst_lrdy",  {31'b0, l_ready}, 32'h0);
    check("rst_crd",   c_rdata, 32'h0);
    check("rst_lrd",   l_rdata, 32'h0);
    // preload RAMs
    pre_we1 = 1; pre_we3 = 1; pre_a = 8'h10; pre_d = 32'hDEADBEEF;
    tick();
    pre_we1 = 0; pre_a = 8'h20; pre_d = 32'hCAFEF00D;
    tick();
    pre_we3 = 0;
    rst_n = 1'b1;
    tick();

    // CPU read alone
    cpu_read1(32'h10, 32'hDEADBEEF, 32'h0);

    // loader write
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h12345678;
    tick();
    check("ldw_c1_en",   {31'b0, m_en}, 32'h1);
    check("ldw_c1_we",   {31'b0, m_we}, 32'h1);
    check("ldw_c1_addr", m_addr, 32'h40);
    check("ldw_c1_wd",   m_wdata, 32'h12345678);
    tick();
    check("ldw_c2_en",   {31'b0, m_en}, 32'h0);
    check("ldw_c2_we",   {31'b0, m_we}, 32'h0);
    check("ldw_c2_addr", m_addr, 32'h40);
    tick();
    check("ldw_c3_rdy",  {31'b0, l_ready}, 32'h1);
    check("ldw_c3_crdy", {31'b0, c_ready}, 32'h0);
    check("ldw_ldata",   l_rdata, 32'h0);
    check("ldw_cdata",   c_rdata, 32'hDEADBEEF);
    l_req = 0; l_we = 0;
    tick();
    check("ldw_c4_rdy",  {31'b0, l_ready}, 32'h0);
    cpu_read1(32'h40, 32'h12345678, 32'h0);

    // both ports request continuously from reset
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    l_req = 1; l_we = 0; l_addr = 32'h40;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rr_en",   {31'b0, m_en},    {31'b0, (k % 4) == 1});
      check("rr_crdy", {31'b0, c_ready}, {31'b0, (k == 3) || (k == 11)});
      check("rr_lrdy", {31'b0, l_ready}, {31'b0, (k == 7) || (k == 15)});
      if ((k % 8) == 1) check("rr_addr_c", m_addr, 32'h10);
      if ((k % 8) == 5) check("rr_addr_l", m_addr, 32'h40);
    end
    c_req = 0; l_req = 0;
    check("rr_cdata", c_rdata, 32'hDEADBEEF);
    check("rr_ldata", l_rdata, 32'h12345678);
    tick();

    // MEM_LAT=3 CPU read
    c3_req = 1; c3_addr = 32'h20;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("l3_en",   {31'b0, m3_en},    {31'b0, k == 1});
      check("l3_crdy", {31'b0, c3_ready}, {31'b0, k == 5});
      check("l3_lrdy", {31'b0, l3_ready}, 32'h0);
      if (k == 5) begin
        check("l3_data", c3_rdata, 32'hCAFEF00D);
        c3_req = 0;
      end
    end
    check("l3_ldata", l3_rdata, 32'h0);

    // reset during WAIT of a CPU read
    c_req = 1; c_we = 0; c_addr = 32'h10;
    tick(); tick();
    rst_n = 1'b0; c_req = 0;
    #1;
    check("mr_en",   {31'b0, m_en}, 32'h0);
    check("mr_we",   {31'b0, m_we}, 32'h0);
    check("mr_addr", m_addr, 32'h0);
    check("mr_crdy", {31'b0, c_ready}, 32'h0);
    check("mr_crd",  c_rdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mr_no_rdy", {31'b0, c_ready}, 32'h0);
      check("mr_no_en",  {31'b0, m_en}, 32'h0);
    end
    cpu_read1(32'h10, 32'hDEADBEEF, 32'h0);

`ifdef MEM_ARB_LD_LOCK_EN
    // loader lock keeps the RAM for the loader across conflicts
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    lk = 1;
    c_req = 1; c_addr = 32'h10; l_req = 1; l_we = 0; l_addr = 32'h40;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 16) begin
        check("lk_lrdy", {31'b0, l_ready}, {31'b0, (k % 4) == 3});
        check("lk_crdy", {31'b0, c_ready}, 32'h0);
      end else begin
        check("lk_crdy2", {31'b0, c_ready}, {31'b0, k == 19});
      end
      if (k == 16) lk = 0;
    end
    c_req = 0; l_req = 0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
